vga_scan_timing: RTL
====================

Name: vga_scan_timing

Overview:
- Generates the 640x480 @ 60 Hz raster scan consumed by every sprite and background renderer: DrawX, DrawY, the visible-area qualifier blank, and the sync pulses sent to the DAC.
- Sprite renderers decode DrawX/DrawY and register their colour one vga_clk later. hs/vs therefore leave through a configurable delay line, so sync stays aligned with the colour pipeline.
- Also provides a vertical-blank strobe and a frame counter. Game logic uses these to update sprite positions (AkumaX/AkumaY etc.) outside the visible region.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width, in clocks
- H_BP, 48, horizontal back porch, in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- SYNC_DELAY, 1, pipeline stages applied to hs/vs (0..4)

Ports:
- vga_clk  input  1  pixel clock (25 MHz)
- reset_n  input  1  asynchronous active-low reset
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = DrawX/DrawY inside the visible area
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY clocks
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY clocks
- vblank_start  output  1  one-clock pulse on the first clock of line V_ACTIVE
- frame_count  output  8  completed frames, wrapping

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Clock and reset: one clock, vga_clk. reset_n is asynchronous, active-low; all flops clear immediately on assertion and release on the next vga_clk edge.
- Reset values: h_cnt=0, v_cnt=0, frame_count=0, every hs/vs delay stage=1. Consequently DrawX=0, DrawY=0, blank=1, hs=1, vs=1, vblank_start=0.
- First clock after release: DrawX=0, DrawY=0 (the counters advance on that edge).
- Horizontal counter: h_cnt increments every clock. At H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on an h_cnt wrap. When h_cnt wraps with v_cnt=V_TOTAL-1, v_cnt also wraps to 0. Both wraps occur on the same edge.
- DrawX = h_cnt and DrawY = v_cnt, driven directly from the registers with no combinational logic after the flops.
- blank = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), decoded from the counter registers. It is aligned with DrawX/DrawY, not delayed.
- Raw horizontal sync: hs_raw = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- Raw vertical sync: vs_raw = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. vs depends only on v_cnt, so it changes at line boundaries only.
- Sync delay line: hs/vs = hs_raw/vs_raw delayed through SYNC_DELAY registered stages. With SYNC_DELAY=0, hs/vs are the combinational raw values.
- vblank_start = 1 iff h_cnt==0 && v_cnt==V_ACTIVE. It is high for exactly one clock per frame.
- frame_count: increments by 1 on the edge where both counters wrap to (0,0). 255 wraps to 0 with no flag.
- Reset mid-frame: counters return to 0 immediately; a partial sync pulse is truncated (hs/vs forced high). No vblank_start is issued for the aborted frame.

Test Plan:
- Reset release: assert reset_n=0 for 3 clocks mid-line (h_cnt≈300), release -> outputs at reset values immediately; DrawX=0,1,2 on successive clocks; hs=vs=1; blank=1.
- Line timing: run 1 line from (0,0) -> blank high for exactly 640 clocks; with SYNC_DELAY=1, hs low for 96 clocks starting on the clock after DrawX=656; DrawX goes 799->0 with DrawY 0->1.
- Frame timing: run 420000 clocks (one frame) -> DrawY spans 0..524; vs low for exactly 2×800 clocks, lines 490-491 (+1 clock delay); vblank_start pulses once, at DrawX=0, DrawY=480; frame_count 0->1 at (799,524)->(0,0).
- Sync delay sweep: SYNC_DELAY=0 and SYNC_DELAY=3 -> falling edge of hs observed at DrawX=656 and 659 respectively; pulse widths unchanged (96 clocks).
- frame_count wrap: run 256 frames -> frame_count 255->0; vblank_start count = 256.
- Non-default geometry: H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1 -> period 14 clocks/line, 7 lines/frame; blank high for 8 clocks on lines 0-3 only; hs low for h_cnt 10-11; vs low on line 5.

Source files
------------

// File: rtl/vga_scan_timing.sv
// Raster scan generator: pixel/line counters, visible-area qualifier,
// delayed active-low sync pulses, vertical-blank strobe and frame counter.
module vga_scan_timing #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned FRAME_W  = 8;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               blank_q, blank_d;
    logic               vbs_q, vbs_d;
    logic               hs_raw_c, vs_raw_c;

    // Next-state for counters; blank and vblank strobe are decoded from the
    // next count so their registers line up with DrawX/DrawY.
    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        frame_d = frame_q;
        if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == CNT_W'(V_TOTAL - 1)) begin
                v_cnt_d = '0;
                frame_d = frame_q + FRAME_W'(1);
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end
        blank_d = (h_cnt_d < CNT_W'(H_ACTIVE)) && (v_cnt_d < CNT_W'(V_ACTIVE));
        vbs_d   = (h_cnt_d == '0) && (v_cnt_d == CNT_W'(V_ACTIVE));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            frame_q <= '0;
            blank_q <= 1'b1;
            vbs_q   <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            frame_q <= frame_d;
            blank_q <= blank_d;
            vbs_q   <= vbs_d;
        end
    end

    always_comb begin
        hs_raw_c = !((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END)));
        vs_raw_c = !((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END)));
    end

    // Sync delay line keeps hs/vs aligned with the renderers' colour register.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hs_raw_c;
            assign vs = vs_raw_c;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hs_raw_c});
                vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vs_raw_c});
            end

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign hs = hs_pipe_q[SYNC_DELAY-1];
            assign vs = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX        = h_cnt_q;
    assign DrawY        = v_cnt_q;
    assign blank        = blank_q;
    assign vblank_start = vbs_q;
    assign frame_count  = frame_q;

endmodule
